// File: rtl/dds_spi_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dds_spi_ctrl
// Description : SPI (mode 0, MSB first) slave that loads a 48-bit phase
//               increment into a DDS compiler. 56-bit frames carry an 8-bit
//               command and a 48-bit payload. A staged/active register pair
//               allows a value to be staged and committed later. Every frame
//               reads back {status, active_pinc} on miso.
// Ports       : clk       - system clock, rising edge
//               rst_n     - synchronous active-low reset
//               sck       - SPI clock (async, <= clk/8)
//               mosi      - SPI data in (async)
//               ssel      - SPI select, active-low (async)
//               miso      - SPI readback data
//               dds_we    - one-cycle DDS write strobe
//               dds_data  - active phase increment
//               frame_err - one-cycle pulse on a bad frame
//               led       - commit counter
// Revision    : 1.0 - initial release
// ============================================================================
module dds_spi_ctrl #(
    parameter int unsigned  SYNC_STAGES  = 2,
    parameter logic [47:0]  DEFAULT_PINC = 48'h0000218DEF41
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sck,
    input  logic        mosi,
    input  logic        ssel,
    output logic        miso,
    output logic        dds_we,
    output logic [47:0] dds_data,
    output logic        frame_err,
    output logic [7:0]  led
);

    localparam logic [5:0] c_FRAME_BITS = 6'd56;
    localparam logic [5:0] c_CNT_SAT    = 6'd57;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EXEC  = 2'd2,
        LOAD  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_q,  sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] ssel_sync_q, ssel_sync_d;
    logic                   sck_prev_q,  ssel_prev_q;

    logic w_sck_s, w_mosi_s, w_ssel_s;
    logic w_sck_rise, w_sck_fall, w_ssel_rise;

    assign sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0],  sck};
    assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    assign ssel_sync_d = {ssel_sync_q[SYNC_STAGES-2:0], ssel};

    assign w_sck_s     = sck_sync_q[SYNC_STAGES-1];
    assign w_mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign w_ssel_s    = ssel_sync_q[SYNC_STAGES-1];

    assign w_sck_rise  = w_sck_s  & ~sck_prev_q;
    assign w_sck_fall  = ~w_sck_s & sck_prev_q;
    assign w_ssel_rise = w_ssel_s & ~ssel_prev_q;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t      state_q,     state_d;
    logic [5:0]  bit_cnt_q,   bit_cnt_d;
    logic [55:0] rx_q,        rx_d;
    logic [55:0] tx_q,        tx_d;
    logic [47:0] staged_q,    staged_d;
    logic [47:0] active_q,    active_d;
    logic [7:0]  led_q,       led_d;
    logic        sticky_q,    sticky_d;
    logic        frame_err_q, frame_err_d;
    logic        dds_we_q,    dds_we_d;
    logic        miso_q,      miso_d;

    logic [7:0]  w_status;
    logic [7:0]  w_cmd;
    logic [47:0] w_payload;

    assign w_status  = {5'b0, sticky_q, (staged_q != active_q), 1'b1};
    assign w_cmd     = rx_q[55:48];
    assign w_payload = rx_q[47:0];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        staged_d    = staged_q;
        active_d    = active_q;
        led_d       = led_q;
        sticky_d    = sticky_q;
        frame_err_d = 1'b0;
        dds_we_d    = 1'b0;
        miso_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // Level-sensitive so a select that went low during EXEC/LOAD
                // is still picked up here.
                if (!w_ssel_s) begin
                    state_d   = SHIFT;
                    bit_cnt_d = 6'd0;
                    tx_d      = {w_status, active_q};
                end
            end
            SHIFT: begin
                if (w_sck_rise) begin
                    rx_d = {rx_q[54:0], w_mosi_s};
                    if (bit_cnt_q != c_CNT_SAT) begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
                if (w_sck_fall) begin
                    tx_d = {tx_q[54:0], 1'b0};
                end
                // Uses bit_cnt_d so a final sck rise coincident with the
                // select rise is counted before the length check.
                if (w_ssel_rise) begin
                    if (bit_cnt_d == c_FRAME_BITS) begin
                        state_d = EXEC;
                    end else begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                case (w_cmd)
                    8'h00: begin
                        sticky_d = 1'b0;
                        state_d  = IDLE;
                    end
                    8'h01: begin
                        staged_d = w_payload;
                        state_d  = IDLE;
                    end
                    8'h02: begin
                        active_d = staged_q;
                        state_d  = LOAD;
                    end
                    8'h03: begin
                        staged_d = w_payload;
                        active_d = w_payload;
                        state_d  = LOAD;
                    end
                    default: begin
                        frame_err_d = 1'b1;
                        sticky_d    = 1'b1;
                        state_d     = IDLE;
                    end
                endcase
            end
            LOAD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The strobe is registered on entry to LOAD so it is high during the
        // LOAD cycle. Reset parks the FSM in LOAD without having entered it,
        // so a LOAD cycle with no strobe yet issues it one cycle late; this
        // produces the single post-reset commit of DEFAULT_PINC.
        dds_we_d = (state_d == LOAD) || ((state_q == LOAD) && !dds_we_q);
        if (dds_we_d) begin
            led_d = led_q + 8'd1;
        end

        if (!w_ssel_s && (state_d == SHIFT)) begin
            miso_d = tx_d[55];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            ssel_sync_q <= '1;
            sck_prev_q  <= 1'b0;
            ssel_prev_q <= 1'b1;
            state_q     <= LOAD;
            bit_cnt_q   <= 6'd0;
            rx_q        <= '0;
            tx_q        <= '0;
            staged_q    <= DEFAULT_PINC;
            active_q    <= DEFAULT_PINC;
            led_q       <= 8'hFF;
            sticky_q    <= 1'b0;
            frame_err_q <= 1'b0;
            dds_we_q    <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ssel_sync_q <= ssel_sync_d;
            sck_prev_q  <= w_sck_s;
            ssel_prev_q <= w_ssel_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            staged_q    <= staged_d;
            active_q    <= active_d;
            led_q       <= led_d;
            sticky_q    <= sticky_d;
            frame_err_q <= frame_err_d;
            dds_we_q    <= dds_we_d;
            miso_q      <= miso_d;
        end
    end

    assign miso      = miso_q;
    assign dds_we    = dds_we_q;
    assign dds_data  = active_q;
    assign frame_err = frame_err_q;
    assign led       = led_q;

endmodule
`default_nettype wire

// File: doc/dds_spi_ctrl.md
DDS_SPI_CTRL -- requirements
Module: dds_spi_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the depth of the synchronizer flip-flop chain on sck, mosi and ssel (minimum 2).
REQ-002 SHALL have parameter DEFAULT_PINC, default 48'h0000218DEF41, meaning the DDS phase increment loaded at reset.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock (100 MHz); all logic runs on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port sck, input, 1 bit: SPI clock from the MCU, asynchronous to clk, at most clk/8.
REQ-006 SHALL have port mosi, input, 1 bit: SPI data from the MCU, asynchronous to clk.
REQ-007 SHALL have port ssel, input, 1 bit: SPI select, active-low, asynchronous to clk.
REQ-008 SHALL have port miso, output, 1 bit: SPI readback data.
REQ-009 SHALL have port dds_we, output, 1 bit: one-cycle write strobe to the DDS compiler.
REQ-010 SHALL have port dds_data, output, 48 bits: active phase increment for the DDS compiler.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad frame.
REQ-012 SHALL have port led, output, 8 bits: commit counter for the board LEDs.

Function
REQ-013 SHALL synchronize sck, mosi and ssel through SYNC_STAGES flip-flops each, and detect sck edges from the synchronized samples only.
REQ-014 SHALL use SPI mode 0, MSB first: sample mosi on synchronized sck rise, update miso on synchronized sck fall.
REQ-015 SHALL use a 56-bit frame: cmd[55:48] followed by payload[47:0].
REQ-016 SHALL implement FSM states IDLE, SHIFT, EXEC and LOAD.
REQ-017 IDLE -> SHIFT when synchronized ssel is low (level, not edge), with the bit counter cleared and the 56-bit tx register loaded with {status, active_pinc}.
REQ-018 status byte SHALL be {5'b0, sticky_err, staged_ne_active, 1'b1}.
REQ-019 In SHIFT, each sck rise SHALL shift mosi into the rx register; the bit counter SHALL saturate at 57.
REQ-020 A synchronized ssel rise with counter==56 SHALL go SHIFT -> EXEC; any other count SHALL go -> IDLE with a frame_err pulse and no register change.
REQ-021 If an sck rise and an ssel rise are detected in the same cycle, the bit SHALL be shifted first and the count then evaluated.
REQ-022 EXEC SHALL last exactly one cycle and decode cmd as follows:
  - 0x00: NOP/readback -> IDLE.
  - 0x01: staged_pinc <= payload -> IDLE.
  - 0x02: active_pinc <= staged_pinc -> LOAD.
  - 0x03: staged_pinc and active_pinc <= payload -> LOAD.
  - any other value: frame_err pulse, sticky_err set -> IDLE.
REQ-023 LOAD SHALL last exactly one cycle, assert dds_we=1 and increment led, then -> IDLE.
REQ-024 led SHALL wrap from 255 to 0.
REQ-025 dds_data SHALL equal active_pinc continuously.
REQ-026 dds_we SHALL rise exactly 2 clk cycles after the cycle in which the synchronized ssel rise is detected.
REQ-027 sticky_err SHALL be cleared by a valid cmd 0x00 frame, after that frame's readback.
REQ-028 miso SHALL be 0 while synchronized ssel is high; otherwise miso SHALL be tx[55], shifting left on each sck fall.
REQ-029 An ssel low level present during EXEC or LOAD SHALL be honoured on return to IDLE (no frame lost).
REQ-030 A frame SHALL NOT change staged_pinc or active_pinc until EXEC.

Reset
REQ-031 When rst_n=0 at a clk edge, the block SHALL set:
  - state = LOAD;
  - staged_pinc = active_pinc = DEFAULT_PINC;
  - led = 0xFF;
  - sticky_err = 0, frame_err = 0, dds_we = 0, miso = 0;
  - synchronizers = idle levels (sck 0, ssel 1).
REQ-032 On the first cycle after rst_n returns high, the block SHALL pulse dds_we once with DEFAULT_PINC, and led SHALL wrap to 0x00.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no register update.

Verification
REQ-034 Release reset -> one dds_we pulse; dds_data=0x0000218DEF41, led=0x00, frame_err never asserted.
REQ-035 Frame 0x03,0x000012345678 at clk/8 -> dds_we one cycle, 2 cycles after the synchronized ssel rise; dds_data=0x000012345678, led=0x01.
REQ-036 Frame 0x01,0x0000AAAA0000, then frame 0x02 -> no dds_we after the first frame; one dds_we after the second; dds_data=0x0000AAAA0000.
REQ-037 40-bit frame, then a 57-bit frame, then a frame with cmd 0x7F -> three frame_err pulses, no dds_we, dds_data unchanged; the next 0x00 readback status=0x05, then 0x01 after clear.
REQ-038 Readback 0x00 after REQ-035 -> miso bits 55..0 = 0x01_000012345678; miso=0 while ssel is high.
REQ-039 256 commits -> led wraps to 0x00; rst_n low after 30 bits of a 0x03 frame -> dds_data returns to DEFAULT_PINC and no frame_err is pulsed.
